shift_left_sched: RTL and testbench

SHIFT_LEFT_SCHED -- requirements
Module: shift_left_sched

---
 rtl/shift_left_sched.sv | 139 +++++++++++++
 tb/tb_shift_left_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_sched.sv
// Two-requester lane shifter: arbitrates A/B, shifts a 96-bit
// operand left by whole 12-bit lanes in passes of up to 5 lanes.
module shift_left_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [95:0] a_data,
   input  logic [3:0]  a_shift,
   input  logic [11:0] a_fill,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [95:0] b_data,
   input  logic [3:0]  b_shift,
   input  logic [11:0] b_fill,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [95:0] out_data,
   output logic        out_src,
   output logic        out_err,
   output logic [1:0]  out_passes
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;
   logic [95:0] data_q, data_d;
   logic [3:0]  rem_q, rem_d;
   logic [11:0] fill_q, fill_d;
   logic        src_q, src_d;
   logic        err_q, err_d;
   logic [1:0]  passes_q, passes_d;

   logic        grant_a, grant_b;
   logic        done;
   logic [3:0]  step;
   logic [3:0]  sh;
   logic [95:0] shifted;

   // Arbitration and output drive; everything is masked while rst is high
   always_comb begin
      grant_a    = a_valid & (~b_valid | ~prio_q);
      grant_b    = b_valid & (~a_valid | prio_q);
      a_ready    = ~rst & (state_q == IDLE) & grant_a;
      b_ready    = ~rst & (state_q == IDLE) & grant_b;
      done       = ~rst & (state_q == DONE);
      out_valid  = done;
      out_data   = done ? data_q : '0;
      out_src    = done & src_q;
      out_err    = done & err_q;
      out_passes = done ? passes_q : 2'd0;
   end

   // One shifter pass: move up to 5 lanes, fill the vacated low lanes
   always_comb begin
      step    = (rem_q > 4'd5) ? 4'd5 : rem_q;
      shifted = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(step))
            shifted[i*12 +: 12] = fill_q;
         else
            shifted[i*12 +: 12] = data_q[(i - int'(step))*12 +: 12];
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      data_d   = data_q;
      rem_d    = rem_q;
      fill_d   = fill_q;
      src_d    = src_q;
      err_d    = err_q;
      passes_d = passes_q;
      sh       = b_ready ? b_shift : a_shift;
      case (state_q)
         IDLE: begin
            if (a_ready | b_ready) begin
               src_d    = b_ready;
               fill_d   = b_ready ? b_fill : a_fill;
               data_d   = b_ready ? b_data : a_data;
               passes_d = 2'd0;
               err_d    = 1'b0;
               rem_d    = sh;
               if (sh > 4'd8) begin
                  err_d   = 1'b1;
                  data_d  = '0;
                  rem_d   = 4'd0;
                  state_d = DONE;
               end else if (sh == 4'd0) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            data_d   = shifted;
            rem_d    = rem_q - step;
            passes_d = passes_q + 2'd1;
            if (rem_q == step)
               state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               prio_d  = ~src_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         data_q   <= '0;
         rem_q    <= '0;
         fill_q   <= '0;
         src_q    <= 1'b0;
         err_q    <= 1'b0;
         passes_q <= '0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         data_q   <= data_d;
         rem_q    <= rem_d;
         fill_q   <= fill_d;
         src_q    <= src_d;
         err_q    <= err_d;
         passes_q <= passes_d;
      end
   end

endmodule

// File: tb/tb_shift_left_sched.sv
// Bench for shift_left_sched: transaction-level model checked every
// cycle, plus directed requests with hand-computed results.
module tb_shift_left_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [95:0] a_data, b_data;
   logic [3:0]  a_shift, b_shift;
   logic [11:0] a_fill, b_fill;
   logic        out_valid, out_ready;
   logic [95:0] out_data;
   logic        out_src, out_err;
   logic [1:0]  out_passes;

   int total = 0;
   int bad   = 0;

   shift_left_sched dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .a_shift(a_shift), .a_fill(a_fill),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
      .b_shift(b_shift), .b_fill(b_fill),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src),
      .out_err(out_err), .out_passes(out_passes)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Whole shift in one step: result = data*2^(12*sh) plus fill in low lanes
   function automatic logic [95:0] model(logic [95:0] d, logic [3:0] sh,
                                         logic [11:0] f);
      logic [191:0] w, m;
      if (sh > 4'd8) return '0;
      w = {96'b0, d} << (12 * sh);
      m = (192'd1 << (12 * sh)) - 192'd1;
      return w[95:0] | ({8{f}} & m[95:0]);
   endfunction

   function automatic logic [1:0] passes_of(logic [3:0] sh);
      if (sh == 0 || sh > 8) return 2'd0;
      return (sh <= 5) ? 2'd1 : 2'd2;
   endfunction

   // Per-cycle transaction model and compare
   bit          busy = 0, m_prio = 0;
   int          cnt, lat;
   logic [95:0] e_data;
   bit          e_src, e_err;
   logic [1:0]  e_pass;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_ready", {a_ready, b_ready}, 0);
         chk("rst_data", out_data, 0);
         chk("rst_flags", {out_src, out_err, out_passes}, 0);
         busy   = 0;
         m_prio = 0;
      end else begin
         bit ga, gb;
         ga = !busy && a_valid && (!b_valid || !m_prio);
         gb = !busy && b_valid && (!a_valid || m_prio);
         chk("ready", {a_ready, b_ready}, {ga, gb});
         if (busy) begin
            cnt++;
            chk("valid", out_valid, cnt >= lat);
            if (cnt >= lat) begin
               chk("data", out_data, e_data);
               chk("src", out_src, e_src);
               chk("err", out_err, e_err);
               chk("passes", out_passes, e_pass);
               if (out_ready) begin
                  busy   = 0;
                  m_prio = !e_src;
               end
            end
         end else begin
            chk("idle_valid", out_valid, 0);
            if (ga || gb) begin
               e_src  = gb;
               e_data = gb ? model(b_data, b_shift, b_fill)
                           : model(a_data, a_shift, a_fill);
               e_err  = gb ? (b_shift > 8) : (a_shift > 8);
               e_pass = gb ? passes_of(b_shift) : passes_of(a_shift);
               lat    = int'(e_pass) + 1;
               busy   = 1;
               cnt    = 0;
            end
         end
      end
   end

   task automatic run(bit use_b, logic [95:0] d, logic [3:0] sh,
                      logic [11:0] f, logic [95:0] x_data, bit x_err,
                      logic [1:0] x_pass, int x_lat, int stall);
      int n;
      @(posedge clk); #1;
      if (use_b) begin
         b_valid = 1; b_data = d; b_shift = sh; b_fill = f;
      end else begin
         a_valid = 1; a_data = d; a_shift = sh; a_fill = f;
      end
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(use_b ? b_ready : a_ready) && n < 20);
      chk("accept_seen", {95'b0, use_b ? b_ready : a_ready}, 1);
      @(posedge clk); #1;
      a_valid = 0; b_valid = 0;
      a_data = ~a_data; b_data = ~b_data;
      a_shift = 4'd2; b_shift = 4'd4;
      a_fill = ~a_fill; b_fill = ~b_fill;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!out_valid && n < 20);
      chk("lit_latency", n, x_lat);
      chk("lit_data", out_data, x_data);
      chk("lit_err", out_err, x_err);
      chk("lit_passes", out_passes, x_pass);
      chk("lit_src", out_src, use_b);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         chk("hold_data", out_data, x_data);
         chk("hold_ready", {a_ready, b_ready}, 0);
      end
      @(posedge clk); #1 out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
      @(negedge clk);
      chk("back_idle", out_valid, 0);
   endtask

   logic [95:0] d1;
   bit          srcs[4];

   initial begin
      int k, n;
      d1 = {12'h008, 12'h007, 12'h006, 12'h005,
            12'h004, 12'h003, 12'h002, 12'h001};
      rst = 1; a_valid = 0; b_valid = 0; out_ready = 0;
      a_data = '0; b_data = '0; a_shift = '0; b_shift = '0;
      a_fill = '0; b_fill = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_valid", out_valid, 0);

      run(0, d1, 4'd3, 12'hFFF,
          {12'h005, 12'h004, 12'h003, 12'h002, 12'h001,
           12'hFFF, 12'hFFF, 12'hFFF}, 0, 2'd1, 2, 0);
      run(0, {84'h0, 12'h123}, 4'd7, 12'hABC,
          {12'h123, {7{12'hABC}}}, 0, 2'd2, 3, 0);
      run(1, d1, 4'd0, 12'h555, d1, 0, 2'd0, 1, 0);
      run(0, d1, 4'd9, 12'h777, 96'h0, 1, 2'd0, 1, 0);
      run(1, d1, 4'd8, 12'h5A5, {8{12'h5A5}}, 0, 2'd2, 3, 5);
      run(0, d1, 4'd5, 12'h000,
          {12'h003, 12'h002, 12'h001, 60'h0}, 0, 2'd1, 2, 0);
      run(1, d1, 4'd6, 12'h111,
          {12'h002, 12'h001, {6{12'h111}}}, 0, 2'd2, 3, 0);
      run(0, d1, 4'd15, 12'h222, 96'h0, 1, 2'd0, 1, 0);

      // Both requesters busy: grants must alternate from A
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      a_valid = 1; a_data = d1; a_shift = 4'd1; a_fill = 12'h0AA;
      b_valid = 1; b_data = ~d1; b_shift = 4'd2; b_fill = 12'h0BB;
      out_ready = 1;
      k = 0; n = 0;
      while (k < 4 && n < 60) begin
         @(negedge clk); n++;
         if (out_valid && out_ready) begin
            srcs[k] = out_src;
            k++;
         end
      end
      @(posedge clk); #1;
      a_valid = 0; b_valid = 0; out_ready = 0;
      chk("alt_count", k, 4);
      for (int i = 0; i < 4; i++)
         chk("alt_src", srcs[i], i % 2);
      repeat (2) @(posedge clk);

      // Reset during the second pass of a shift-8 request
      run(0, d1, 4'd1, 12'h333,
          {12'h007, 12'h006, 12'h005, 12'h004,
           12'h003, 12'h002, 12'h001, 12'h333}, 0, 2'd1, 2, 0);
      @(posedge clk); #1;
      b_valid = 1; b_data = d1; b_shift = 4'd8; b_fill = 12'h444;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!b_ready && n < 20);
      chk("r8_accept", b_ready, 1);
      @(posedge clk); #1 b_valid = 0;
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      a_valid = 1; a_shift = 4'd2; a_fill = 12'h666;
      b_valid = 1; b_shift = 4'd2;
      @(negedge clk);
      chk("r8_idle_valid", out_valid, 0);
      chk("r8_prio_grant", {a_ready, b_ready}, 2'b10);
      @(posedge clk); #1 a_valid = 0; b_valid = 0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!out_valid && n < 20);
      chk("r8_next_src", out_src, 0);
      @(posedge clk); #1 out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
